// File: rtl/grad_mag_bin.sv
// HOG gradient post-processor: gx^2+gy^2 for the sqrt stage plus an unsigned 9-bin orientation.
// mag_sq 3 cycles after input, bin/last 3+ALIGN_DLY cycles after; no backpressure, 1 pixel/clk.
module grad_mag_bin #(
  parameter int GRAD_W    = 9,
  parameter int MAG_W     = 18,
  parameter int ALIGN_DLY = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [GRAD_W-1:0] gx,
  input  logic signed [GRAD_W-1:0] gy,
  input  logic                     in_last,
  output logic [MAG_W-1:0]         mag_sq,
  output logic                     mag_sq_valid,
  output logic [3:0]               bin_o,
  output logic                     bin_valid,
  output logic                     last_o
);

  // Every product and t_k fits this width exactly for |g| <= 255 and Q8 coefficients.
  localparam int T_W = 2 * GRAD_W + 1;
  localparam int NK  = 8;

  localparam int COS_Q8 [NK] = '{241, 196, 128, 44, -44, -128, -196, -241};
  localparam int SIN_Q8 [NK] = '{88, 165, 222, 252, 252, 222, 165, 88};

  localparam logic signed [GRAD_W-1:0] G_MIN     = {1'b1, {(GRAD_W-1){1'b0}}};
  localparam logic signed [GRAD_W-1:0] G_MIN_SAT = {1'b1, {(GRAD_W-2){1'b0}}, 1'b1};

  typedef struct packed {
    logic       vld;
    logic       last;
    logic [3:0] bin;
  } align_t;

  // ---------------- S1: saturate and fold into [0,180) ----------------
  logic signed [GRAD_W-1:0] gx_sat, gy_sat, gx_fold, gy_fold;

  always_comb begin
    gx_sat  = (gx == G_MIN) ? G_MIN_SAT : gx;
    gy_sat  = (gy == G_MIN) ? G_MIN_SAT : gy;
    gx_fold = gx_sat;
    gy_fold = gy_sat;
    if (gy_sat[GRAD_W-1]) begin
      gx_fold = -gx_sat;
      gy_fold = -gy_sat;
    end else if ((gy_sat == '0) && gx_sat[GRAD_W-1]) begin
      gx_fold = -gx_sat;
    end
  end

  logic                     s1_vld, s1_last, s1_zero;
  logic signed [GRAD_W-1:0] s1_gx, s1_gy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_zero <= 1'b0;
      s1_gx   <= '0;
      s1_gy   <= '0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_zero <= (gx_sat == '0) && (gy_sat == '0);
        s1_gx   <= gx_fold;
        s1_gy   <= gy_fold;
      end
    end
  end

  // ---------------- S2: squares and boundary projections ----------------
  logic signed [T_W-1:0]   gx_ext, gy_ext;
  logic [NK-1:0][T_W-1:0]  t_nxt;

  assign gx_ext = {{(T_W-GRAD_W){s1_gx[GRAD_W-1]}}, s1_gx};
  assign gy_ext = {{(T_W-GRAD_W){s1_gy[GRAD_W-1]}}, s1_gy};

  for (genvar k = 0; k < NK; k++) begin : g_tk
    localparam logic signed [T_W-1:0] CK = T_W'(COS_Q8[k]);
    localparam logic signed [T_W-1:0] SK = T_W'(SIN_Q8[k]);
    logic signed [T_W-1:0] t_k;
    assign t_k      = gy_ext * CK - gx_ext * SK;
    assign t_nxt[k] = t_k;
  end

  logic                   s2_vld, s2_last, s2_zero;
  logic [MAG_W-1:0]       s2_sq;
  logic [NK-1:0][T_W-1:0] s2_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_zero <= 1'b0;
      s2_sq   <= '0;
      s2_t    <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_last <= s1_last;
        s2_zero <= s1_zero;
        s2_sq   <= MAG_W'(gx_ext * gx_ext + gy_ext * gy_ext);
        s2_t    <= t_nxt;
      end
    end
  end

  // ---------------- S3: thermometer count ----------------
  logic [3:0] bin_cnt;

  always_comb begin
    bin_cnt = '0;
    for (int k = 0; k < NK; k++) begin
      bin_cnt = bin_cnt + {3'b000, ~s2_t[k][T_W-1]};
    end
    // The origin satisfies every t_k >= 0; report it as bin 0 instead of 8.
    if (s2_zero) begin
      bin_cnt = '0;
    end
  end

  logic             s3_vld, s3_last;
  logic [MAG_W-1:0] s3_mag;
  logic [3:0]       s3_bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld  <= 1'b0;
      s3_last <= 1'b0;
      s3_mag  <= '0;
      s3_bin  <= '0;
    end else begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_last <= s2_last;
        s3_mag  <= s2_zero ? '0 : s2_sq;
        s3_bin  <= bin_cnt;
      end
    end
  end

  assign mag_sq       = s3_mag;
  assign mag_sq_valid = s3_vld;

  // ---------------- Align bin/last with the square-root result ----------------
  align_t                      align_head;
  align_t [ALIGN_DLY-1:0]      align_q;

  always_comb begin
    align_head = '0;
    if (s3_vld) begin
      align_head.vld  = 1'b1;
      align_head.last = s3_last;
      align_head.bin  = s3_bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_q <= '0;
    end else begin
      align_q <= {align_q[ALIGN_DLY-2:0], align_head};
    end
  end

  assign bin_o     = align_q[ALIGN_DLY-1].bin;
  assign bin_valid = align_q[ALIGN_DLY-1].vld;
  assign last_o    = align_q[ALIGN_DLY-1].last;

endmodule

// File: doc/grad_mag_bin.md
# grad_mag_bin

Streaming HOG gradient post-processor between the pixel-difference stage and the pipelined square-root stage. Per valid pixel it takes signed gradients (gx, gy), produces gx²+gy² as an 18-bit operand for the square-root stage, and computes the unsigned-orientation bin (9 bins over 0–180°). Bin and sideband are delayed so they arrive in the same cycle as the matching square-root result, which the histogram accumulator downstream consumes.

## Interface
- GRAD_W, 9: signed gradient width. Legal input range is ±255.
- MAG_W, 18: squared-magnitude width. Equals the square-root stage IN_W.
- ALIGN_DLY, 13: extra delay on bin/last/valid. Equals the square-root latency (its OUT_W, 13 for IN_W=18 with 4 fraction bits).
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  gx/gy/in_last qualify this cycle.
- gx  input  GRAD_W  signed horizontal gradient.
- gy  input  GRAD_W  signed vertical gradient.
- in_last  input  1  last pixel of cell/row; sideband passed through.
- mag_sq  output  MAG_W  gx²+gy², connects to the square-root input.
- mag_sq_valid  output  1  mag_sq qualifier.
- bin_o  output  4  orientation bin 0..8, aligned with the square-root output.
- bin_valid  output  1  bin_o qualifier; also qualifies the square-root output.
- last_o  output  1  in_last aligned with bin_o.

## Operation
- No backpressure. One pixel per cycle is accepted at full rate, and gaps (in_valid=0) are allowed anywhere.
- **S1 (fold), registered:**
  - Saturate the value −256 to −255.
  - If gy<0: negate both gx and gy.
  - If gy==0 and gx<0: negate gx, so 180° maps to 0°.
  - Result: gy'≥0, and the angle lies in [0°,180°).
- **S2 (multiply), registered:**
  - sq = gx'² + gy'² in 18 bits unsigned. The maximum is 130050, so there is no overflow.
  - For k=1..8, t_k = gy'·C_k − gx'·S_k, a signed 19-bit value.
  - Q8 constants (C,S):
    - 20° (241,88), 40° (196,165), 60° (128,222), 80° (44,252)
    - 100° (−44,252), 120° (−128,222), 140° (−196,165), 160° (−241,88)
- **S3 (count), registered:**
  - bin = number of k with t_k ≥ 0. The thermometer collapses to 0..8.
  - mag_sq is driven from S3.
  - Exact-boundary cases are decided solely by the integer t_k expression; ≥0 counts.
- gx=gy=0 gives bin 8 from the formula. It is forced to bin 0, and mag_sq=0.
- **Align:** {bin, last, valid} pass from S3 through an ALIGN_DLY-deep shift register, advancing every cycle regardless of valid.
  - Entries with valid=0 propagate as bubbles.
  - Data bits of bubble entries are don't-care, but are driven 0.
- A valid bit travels through every stage. Data registers capture only when the previous stage is valid and otherwise hold.

## Timing
- mag_sq/mag_sq_valid: 3 cycles after in_valid is sampled.
- bin_o/bin_valid/last_o: 3+ALIGN_DLY cycles after in_valid is sampled (16 by default). This equals the cycle the square-root result for the same pixel appears.
- Throughput: 1 pixel/clk. Ordering is strictly preserved.
- **Reset:** all outputs are 0 and all valid bits are 0 while rst_n=0.
  - Assertion is asynchronous, mid-stream included.
  - In-flight pixels are discarded, not emitted later.
  - The first input accepted on the first rising edge after deassertion appears at the normal latency.
- Simultaneous events: in_last with in_valid=0 is ignored (last is only captured with valid).

## Test plan
- gx=100, gy=0, single valid → cycle 3: mag_sq=10000, mag_sq_valid=1; cycle 16: bin_o=0, bin_valid=1.
- gx=0, gy=100 → mag_sq=10000, bin_o=4. gx=−100, gy=0 → mag_sq=10000, bin_o=0 (180° fold).
- gx=−255, gy=−255 with in_last=1 → mag_sq=130050, bin_o=2, last_o=1 on the bin_valid cycle. gx=−100, gy=10 → bin_o=8.
- Back-to-back 32 random ±255 pairs with random valid gaps → bins match a golden atan2 model using the Q8 t_k rule. The bin_valid pattern equals the in_valid pattern shifted 16 cycles; mag_sq matches exactly.
- gx=gy=0 → mag_sq=0, bin_o=0. gx=−256 → treated as −255 (mag_sq=65025, bin 0).
- Assert rst_n=0 while 10 pixels are in flight → all outputs are 0 immediately and no stale valid appears after release. A pixel sent 1 cycle after release emerges at cycles 3 and 16.
